program_control_unit: RTL and testbench

Parametrised program-flow controller for the 4-bit microprocessor family: the next generation of the program counter / phase toggle / fetch-register group. It generates the fetch/execute phase, latches the instruction and operand fields from program memory, and updates the program counter on increment, jump, subroutine call and return. A hardware return-address stack with full/empty/error status and a global hold input are new in this generation. It sits between program ROM (drives its address, receives `program_byte`) and the decoder, which supplies the PC commands.

---
 rtl/program_control_unit.sv | 149 ++++++++++++++
 tb/tb_program_control_unit.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/program_control_unit.sv
// Program-flow controller: fetch/execute phase, instruction latch,
// program counter with jump/call/return and a hardware return-address stack.
module program_control_unit #(
    parameter int AW          = 12,
    parameter int IW          = 8,
    parameter int OPW         = 4,
    parameter int STACK_DEPTH = 4
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             hold,
    input  logic [IW-1:0]                    program_byte,
    input  logic                             inc_pc,
    input  logic                             load_pc,
    input  logic                             call,
    input  logic                             ret,
    input  logic [AW-1:0]                    target,
    output logic [AW-1:0]                    PC,
    output logic                             phase,
    output logic [IW-OPW-1:0]                instr,
    output logic [OPW-1:0]                   oprnd,
    output logic [$clog2(STACK_DEPTH+1)-1:0] sp,
    output logic                             stack_full,
    output logic                             stack_empty,
    output logic                             stack_err
);

    localparam int SPW = $clog2(STACK_DEPTH + 1);
    // Stack index width; at least one bit so a depth-1 stack still has an index.
    localparam int AIW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [SPW-1:0] SP_MAX = SPW'(STACK_DEPTH);

    typedef enum logic {
        FETCH   = 1'b0,
        EXECUTE = 1'b1
    } phase_t;

    phase_t            state_q;
    phase_t            state_d;
    logic [AW-1:0]     pc_q;
    logic [AW-1:0]     pc_d;
    logic [AW-1:0]     pc_inc;
    logic [IW-OPW-1:0] instr_q;
    logic [IW-OPW-1:0] instr_d;
    logic [OPW-1:0]    oprnd_q;
    logic [OPW-1:0]    oprnd_d;
    logic [SPW-1:0]    sp_q;
    logic [SPW-1:0]    sp_d;
    logic              err_q;
    logic              err_d;
    logic              push_en;
    logic [AIW-1:0]    wr_idx;
    logic [AIW-1:0]    rd_idx;

    // Return-address storage; entries above sp are stale and never read.
    logic [AW-1:0] stack_mem [2**AIW];

    // Increment wraps modulo 2^AW, used for both inc_pc and pushed returns.
    assign pc_inc = pc_q + AW'(1);
    assign wr_idx = AIW'(sp_q);
    assign rd_idx = AIW'(sp_q - SPW'(1));

    // Next-state decode: fetch latches the program byte, execute applies
    // the highest-priority command (ret > call > load_pc > inc_pc).
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        oprnd_d = oprnd_q;
        sp_d    = sp_q;
        err_d   = err_q;
        push_en = 1'b0;
        if (!hold) begin
            case (state_q)
                FETCH: begin
                    state_d = EXECUTE;
                    instr_d = program_byte[IW-1:OPW];
                    oprnd_d = program_byte[OPW-1:0];
                end
                EXECUTE: begin
                    state_d = FETCH;
                    if (ret) begin
                        if (sp_q != '0) begin
                            pc_d = stack_mem[rd_idx];
                            sp_d = sp_q - SPW'(1);
                        end else begin
                            // Underflow: skip the return, flag it.
                            pc_d  = pc_inc;
                            err_d = 1'b1;
                        end
                    end else if (call) begin
                        if (sp_q != SP_MAX) begin
                            push_en = 1'b1;
                            sp_d    = sp_q + SPW'(1);
                            pc_d    = target;
                        end else begin
                            // Overflow: stack untouched, fall through.
                            pc_d  = pc_inc;
                            err_d = 1'b1;
                        end
                    end else if (load_pc) begin
                        pc_d = target;
                    end else if (inc_pc) begin
                        pc_d = pc_inc;
                    end
                end
                default: begin
                    state_d = FETCH;
                end
            endcase
        end
    end

    // Architectural registers with asynchronous reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= FETCH;
            pc_q    <= '0;
            instr_q <= '0;
            oprnd_q <= '0;
            sp_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            oprnd_q <= oprnd_d;
            sp_q    <= sp_d;
            err_q   <= err_d;
        end
    end

    // Stack write port; contents need no reset since sp gates every read.
    always_ff @(posedge clock) begin
        if (push_en) begin
            stack_mem[wr_idx] <= pc_inc;
        end
    end

    assign PC          = pc_q;
    assign phase       = state_q;
    assign instr       = instr_q;
    assign oprnd       = oprnd_q;
    assign sp          = sp_q;
    assign stack_err   = err_q;
    assign stack_full  = (sp_q == SP_MAX);
    assign stack_empty = (sp_q == '0);

endmodule

// File: tb/tb_program_control_unit.sv
// Self-checking bench for program_control_unit: table-driven edges with
// expected observations queued on drive and compared after each edge.
module tb_program_control_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic        hold;
    logic [7:0]  program_byte;
    logic        inc_pc;
    logic        load_pc;
    logic        call;
    logic        ret;
    logic [11:0] target;
    logic [11:0] PC;
    logic        phase;
    logic [3:0]  instr;
    logic [3:0]  oprnd;
    logic [2:0]  sp;
    logic        stack_full;
    logic        stack_empty;
    logic        stack_err;

    program_control_unit #(
        .AW(12), .IW(8), .OPW(4), .STACK_DEPTH(4)
    ) dut (
        .clock(clock),
        .reset(reset),
        .hold(hold),
        .program_byte(program_byte),
        .inc_pc(inc_pc),
        .load_pc(load_pc),
        .call(call),
        .ret(ret),
        .target(target),
        .PC(PC),
        .phase(phase),
        .instr(instr),
        .oprnd(oprnd),
        .sp(sp),
        .stack_full(stack_full),
        .stack_empty(stack_empty),
        .stack_err(stack_err)
    );

    always #5 clock = ~clock;

    // Command bits: {hold, ret, call, load_pc, inc_pc}
    localparam logic [4:0] NONE = 5'b00000;
    localparam logic [4:0] INC  = 5'b00001;
    localparam logic [4:0] LD   = 5'b00010;
    localparam logic [4:0] CALL = 5'b00100;
    localparam logic [4:0] RET  = 5'b01000;
    localparam logic [4:0] HOLD = 5'b10000;

    // {PC, phase, instr, oprnd, sp, full, empty, err}
    typedef logic [26:0] obs_t;

    typedef struct {
        logic [4:0]  cmd;
        logic [11:0] tgt;
        logic [7:0]  pb;
        obs_t        exp;
    } vec_t;

    vec_t        tbl[$];
    obs_t        exp_q[$];
    int          checks = 0;
    int          failures = 0;

    logic [11:0] e_pc;
    logic [3:0]  e_ins;
    logic [3:0]  e_opr;
    logic [2:0]  e_sp;
    logic        e_err;

    localparam obs_t RESET_OBS = {12'h000, 1'b0, 4'h0, 4'h0, 3'd0,
                                  1'b0, 1'b1, 1'b0};

    wire obs_t got_obs = {PC, phase, instr, oprnd, sp,
                          stack_full, stack_empty, stack_err};

    function automatic obs_t mk_obs(logic ph);
        return {e_pc, ph, e_ins, e_opr, e_sp,
                (e_sp == 3'd4), (e_sp == 3'd0), e_err};
    endfunction

    task automatic clr_model();
        e_pc  = '0;
        e_ins = '0;
        e_opr = '0;
        e_sp  = '0;
        e_err = 1'b0;
    endtask

    // Fetch edge: instruction/operand come from the program byte.
    task automatic fe(logic [4:0] c, logic [11:0] t, logic [7:0] b);
        vec_t v;
        e_ins = b[7:4];
        e_opr = b[3:0];
        v.cmd = c;
        v.tgt = t;
        v.pb  = b;
        v.exp = mk_obs(1'b1);
        tbl.push_back(v);
    endtask

    // Execute edge with hand-computed PC/sp/err results.
    task automatic ex(logic [4:0] c, logic [11:0] t, logic [11:0] pc,
                      logic [2:0] s, logic er);
        vec_t v;
        e_pc  = pc;
        e_sp  = s;
        e_err = er;
        v.cmd = c;
        v.tgt = t;
        v.pb  = 8'hEE;
        v.exp = mk_obs(1'b0);
        tbl.push_back(v);
    endtask

    // Held edge: everything frozen, phase stays as given.
    task automatic hd(logic [4:0] c, logic [11:0] t, logic [7:0] b,
                      logic ph);
        vec_t v;
        v.cmd = c | HOLD;
        v.tgt = t;
        v.pb  = b;
        v.exp = mk_obs(ph);
        tbl.push_back(v);
    endtask

    task automatic compare(string name, int idx, obs_t got, obs_t exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s[%0d] got=%h expected=%h", name, idx, got, exp);
        end
    endtask

    task automatic drive(vec_t v, string name, int idx);
        obs_t e;
        {hold, ret, call, load_pc, inc_pc} = v.cmd;
        target       = v.tgt;
        program_byte = v.pb;
        exp_q.push_back(v.exp);
        @(posedge clock);
        #1;
        e = exp_q.pop_front();
        compare(name, idx, got_obs, e);
    endtask

    task automatic run(string name);
        foreach (tbl[i]) drive(tbl[i], name, i);
        tbl.delete();
    endtask

    // Reset pulse between edges; outputs must clear without a clock edge.
    task automatic reset_pulse(string name);
        {hold, ret, call, load_pc, inc_pc} = NONE;
        #2;
        reset = 1'b1;
        #1;
        compare(name, 0, got_obs, RESET_OBS);
        #1;
        reset = 1'b0;
        clr_model();
    endtask

    initial begin
        reset        = 1'b1;
        {hold, ret, call, load_pc, inc_pc} = NONE;
        target       = '0;
        program_byte = '0;
        clr_model();
        #12;
        compare("reset_state", 0, got_obs, RESET_OBS);
        @(negedge clock);
        reset = 1'b0;

        // Fetch/increment, call/return, wrap, priority, hold, underflow.
        fe(NONE, 12'h000, 8'hA5);
        ex(INC,  12'h000, 12'h001, 3'd0, 1'b0);
        fe(NONE, 12'h000, 8'h00);
        ex(LD,   12'h010, 12'h010, 3'd0, 1'b0);
        fe(NONE, 12'h000, 8'h3C);
        ex(CALL, 12'h200, 12'h200, 3'd1, 1'b0);
        fe(NONE, 12'h000, 8'h12);
        ex(RET,  12'h000, 12'h011, 3'd0, 1'b0);
        fe(CALL | LD, 12'h123, 8'h77);
        ex(NONE, 12'h456, 12'h011, 3'd0, 1'b0);
        fe(NONE, 12'h000, 8'h00);
        ex(LD,   12'hFFF, 12'hFFF, 3'd0, 1'b0);
        fe(NONE, 12'h000, 8'h01);
        ex(INC,  12'h000, 12'h000, 3'd0, 1'b0);
        fe(NONE, 12'h000, 8'h02);
        ex(LD,   12'hFFF, 12'hFFF, 3'd0, 1'b0);
        fe(NONE, 12'h000, 8'h03);
        ex(CALL | LD | INC, 12'h400, 12'h400, 3'd1, 1'b0);
        fe(NONE, 12'h000, 8'h04);
        ex(RET,  12'h000, 12'h000, 3'd0, 1'b0);
        fe(NONE, 12'h000, 8'h5A);
        for (int i = 0; i < 3; i++) hd(LD, 12'h0AB, 8'hFF, 1'b1);
        ex(LD,   12'h0AB, 12'h0AB, 3'd0, 1'b0);
        hd(INC,  12'h000, 8'hFF, 1'b0);
        fe(NONE, 12'h000, 8'h00);
        ex(LD,   12'h050, 12'h050, 3'd0, 1'b0);
        fe(NONE, 12'h000, 8'h00);
        ex(RET | CALL, 12'h777, 12'h051, 3'd0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            fe(NONE, 12'h000, 8'(i * 17));
            ex(INC, 12'h000, 12'h052 + 12'(i), 3'd0, 1'b1);
        end
        run("basic");

        reset_pulse("reset_clears_err");

        // Five nested calls with depth 4, then LIFO unwind.
        fe(NONE, 12'h000, 8'h10);
        ex(LD,   12'h100, 12'h100, 3'd0, 1'b0);
        fe(NONE, 12'h000, 8'h20);
        ex(CALL, 12'h110, 12'h110, 3'd1, 1'b0);
        fe(NONE, 12'h000, 8'h21);
        ex(CALL, 12'h120, 12'h120, 3'd2, 1'b0);
        fe(NONE, 12'h000, 8'h22);
        ex(CALL, 12'h130, 12'h130, 3'd3, 1'b0);
        fe(NONE, 12'h000, 8'h23);
        ex(CALL, 12'h300, 12'h300, 3'd4, 1'b0);
        fe(NONE, 12'h000, 8'h24);
        ex(CALL, 12'h555, 12'h301, 3'd4, 1'b1);
        fe(NONE, 12'h000, 8'h30);
        ex(RET,  12'h000, 12'h131, 3'd3, 1'b1);
        fe(NONE, 12'h000, 8'h31);
        ex(RET,  12'h000, 12'h121, 3'd2, 1'b1);
        fe(NONE, 12'h000, 8'h32);
        ex(RET,  12'h000, 12'h111, 3'd1, 1'b1);
        fe(NONE, 12'h000, 8'h33);
        ex(RET,  12'h000, 12'h101, 3'd0, 1'b1);
        run("overflow");

        reset_pulse("reset_after_overflow");

        // Reach sp = 2, then reset mid-cycle; first edge after is a fetch.
        fe(NONE, 12'h000, 8'h40);
        ex(CALL, 12'h0A0, 12'h0A0, 3'd1, 1'b0);
        fe(NONE, 12'h000, 8'h41);
        ex(CALL, 12'h0B0, 12'h0B0, 3'd2, 1'b0);
        run("sp2_setup");

        reset_pulse("reset_at_sp2");

        fe(INC, 12'h000, 8'hC3);
        ex(NONE, 12'h000, 12'h000, 3'd0, 1'b0);
        run("after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
